switch_sequencer: RTL
=====================

Name: switch_sequencer

Overview:
- Tick-driven controller for the photonic switch bank.
- Holds a programmable table of up to 2^STEP_W switch states, each with its own dwell time in ticks. Steps through the table once, or loops it, when started.
- The tick strobe comes from the 1 MHz enable generator, so one tick is 1 us.
- When the switch pattern changes between steps, the block inserts an all-off dead time so no two paths are ever on at once (break-before-make).

Parameters:
- N_SW, 4, number of switch drive lines.
- STEP_W, 3, table address width; table depth is 2^STEP_W = 8.
- DWELL_W, 8, dwell field width, in ticks.
- DEAD_W, 4, dead-time width, in ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en_tick  in  1  one-clk-wide time-base strobe; 1 MHz in the system.
- start  in  1  pulse; begin the sequence.
- stop  in  1  pulse; abort the sequence.
- loop  in  1  sampled at start; 1 = repeat the table indefinitely.
- num_steps  in  STEP_W+1  number of steps to run; sampled at start; valid range 1..2^STEP_W.
- dead_time  in  DEAD_W  all-off gap in ticks; sampled at start; 0 = no gap.
- wr_en  in  1  table write strobe.
- wr_addr  in  STEP_W  table entry to write.
- wr_state  in  N_SW  switch pattern for the entry.
- wr_dwell  in  DWELL_W  dwell of the entry, in ticks.
- sw_out  out  N_SW  registered switch drive.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- step_idx  out  STEP_W  index of the current step.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when stop ends a run.
- cfg_err  out  1  one-cycle pulse on a rejected start or write.

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - sw_out, step_idx, busy, done, aborted, cfg_err and tick counter all 0.
  - Table contents are not reset; they are undefined until written.
- Table writes:
  - A write with wr_en=1 in IDLE updates the entry at the next clk edge.
  - wr_en while busy: write ignored, cfg_err pulses.
- States: IDLE, DRIVE, DEAD, FINISH.
- IDLE:
  - sw_out = 0.
  - start with 1 <= num_steps <= 2^STEP_W: latch num_steps, loop and dead_time; step_idx <= 0; enter DRIVE.
  - On the following cycle, sw_out = table[0].state and busy = 1 (1-cycle latency).
  - start with num_steps = 0 or num_steps > 2^STEP_W: stay IDLE, cfg_err pulses.
  - start and stop in the same cycle: stop wins; no action, no pulse.
- DRIVE:
  - sw_out = table[step_idx].state.
  - Tick counter clears on entry and counts en_tick cycles, including a tick in the entry cycle.
  - Effective dwell D = wr_dwell, with 0 treated as 1.
  - On the cycle the D-th tick is seen, compute next = step_idx+1, or 0 if the last step and loop=1.
    - Last step and loop=0: go to FINISH.
    - Otherwise, latched dead_time != 0 and table[next].state != current state: go to DEAD, with step_idx <= next.
    - Otherwise: go to DRIVE at next; counter restarts; sw_out updates at the next edge.
- DEAD:
  - sw_out = 0.
  - Counter counts ticks; after dead_time ticks, go to DRIVE at step_idx.
- FINISH:
  - sw_out = 0, done = 1 for one cycle, busy = 0.
  - Then IDLE; step_idx holds its last value.
- stop in DRIVE, DEAD or FINISH:
  - Next edge: IDLE, sw_out = 0, busy = 0, aborted pulses, done is not asserted.
  - stop in IDLE: no effect.
- start while busy: ignored, no error pulse.
- Counters:
  - Tick counter is max(DWELL_W, DEAD_W) bits and never wraps, because the compare terminates it first.
  - step_idx wraps to 0 only via loop=1.
- sw_out is a single registered vector; there is no cycle in which the old and new patterns are both partly applied.

Test Plan:
- Table {0:0001/d2, 1:0010/d3}, num_steps=2, loop=0, dead_time=0, en_tick every 4 clk, start:
  - sw_out = 0001 for 2 ticks, then 0010 for 3 ticks.
  - Then 0000 with a done pulse; busy falls the same cycle as done.
- Same table, dead_time=1:
  - 0000 for exactly 1 tick between 0001 and 0010.
  - If entry 1 is set to 0001, there is no gap.
- loop=1, num_steps=2:
  - Sequence 0001, 0010, 0001, ... repeats with step_idx 0,1,0,1.
  - stop mid-step 1 gives sw_out = 0000, aborted pulse, no done.
- Error cases:
  - start with num_steps=0 or 9: cfg_err pulses, busy stays 0.
  - wr_en while busy: cfg_err pulses and the table is unchanged after the run.
- wr_dwell=0 entry: lasts exactly 1 tick.
- Control conflicts:
  - start and stop together in IDLE: nothing happens.
  - Second start while busy: no restart.
- reset asserted mid-DRIVE: sw_out = 0000 immediately (asynchronous), before the next clk edge; the block is IDLE after release.

Source files
------------

// File: rtl/switch_sequencer_if.sv
// Control, table-write and status bundle for the photonic switch sequencer.
// The master side drives control and table writes; the slave side is the sequencer.
interface switch_sequencer_if #(
  parameter int N_SW    = 4,
  parameter int STEP_W  = 3,
  parameter int DWELL_W = 8,
  parameter int DEAD_W  = 4
);
  logic               en_tick;
  logic               start;
  logic               stop;
  logic               loop;
  logic [STEP_W:0]    num_steps;
  logic [DEAD_W-1:0]  dead_time;
  logic               wr_en;
  logic [STEP_W-1:0]  wr_addr;
  logic [N_SW-1:0]    wr_state;
  logic [DWELL_W-1:0] wr_dwell;
  logic [N_SW-1:0]    sw_out;
  logic               busy;
  logic [STEP_W-1:0]  step_idx;
  logic               done;
  logic               aborted;
  logic               cfg_err;

  modport master (
    output en_tick, start, stop, loop, num_steps, dead_time,
    output wr_en, wr_addr, wr_state, wr_dwell,
    input  sw_out, busy, step_idx, done, aborted, cfg_err
  );

  modport slave (
    input  en_tick, start, stop, loop, num_steps, dead_time,
    input  wr_en, wr_addr, wr_state, wr_dwell,
    output sw_out, busy, step_idx, done, aborted, cfg_err
  );
endinterface

// File: rtl/switch_sequencer.sv
// Tick-driven switch-bank sequencer: steps a programmable pattern/dwell table,
// inserting an all-off dead time whenever the pattern changes (break-before-make).
module switch_sequencer #(
  parameter int N_SW    = 4,
  parameter int STEP_W  = 3,
  parameter int DWELL_W = 8,
  parameter int DEAD_W  = 4
) (
  input logic              clk,
  input logic              reset,
  switch_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << STEP_W;
  localparam int CNT_W = (DWELL_W > DEAD_W) ? DWELL_W : DEAD_W;

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD, FINISH} state_t;

  state_t             state_q, state_d;
  logic [N_SW-1:0]    tbl_state [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]  idx_q, idx_d, nxt_idx;
  logic [STEP_W:0]    num_q;
  logic               loop_q;
  logic [DEAD_W-1:0]  dead_q;
  logic [N_SW-1:0]    sw_q, sw_d;
  logic               busy_q, done_q, aborted_q, cfg_err_q;
  logic               load_cfg, aborted_d, cfg_err_d;
  logic               last_step, start_ok;
  logic [CNT_W:0]     ticks_seen, dwell_eff, dead_eff;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    load_cfg   = 1'b0;
    aborted_d  = 1'b0;
    cfg_err_d  = bus.wr_en && (state_q != IDLE);

    // Ticks seen so far in this step, counting a tick in the current cycle.
    ticks_seen = {1'b0, cnt_q} + {{CNT_W{1'b0}}, bus.en_tick};
    dwell_eff  = {{(CNT_W + 1 - DWELL_W){1'b0}}, tbl_dwell[idx_q]};
    if (tbl_dwell[idx_q] == '0) dwell_eff = {{CNT_W{1'b0}}, 1'b1};
    dead_eff   = {{(CNT_W + 1 - DEAD_W){1'b0}}, dead_q};

    last_step  = ({1'b0, idx_q} == (num_q - 1'b1));
    nxt_idx    = (last_step && loop_q) ? '0 : idx_q + 1'b1;
    start_ok   = (bus.num_steps != '0) &&
                 (bus.num_steps <= {1'b1, {STEP_W{1'b0}}});

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (start_ok) begin
            load_cfg = 1'b1;
            idx_d    = '0;
            cnt_d    = '0;
            state_d  = DRIVE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        cnt_d = ticks_seen[CNT_W-1:0];
        if (bus.en_tick && (ticks_seen == dwell_eff)) begin
          cnt_d = '0;
          if (last_step && !loop_q) begin
            state_d = FINISH;
          end else begin
            idx_d = nxt_idx;
            if ((dead_q != '0) && (tbl_state[nxt_idx] != tbl_state[idx_q]))
              state_d = DEAD;
          end
        end
      end
      DEAD: begin
        cnt_d = ticks_seen[CNT_W-1:0];
        if (bus.en_tick && (ticks_seen == dead_eff)) begin
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.stop && (state_q != IDLE)) begin
      state_d   = IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end

    // Drive is derived from the next state so the pattern changes in one edge.
    sw_d = (state_d == DRIVE) ? tbl_state[idx_d] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      num_q     <= '0;
      loop_q    <= 1'b0;
      dead_q    <= '0;
      sw_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sw_q      <= sw_d;
      busy_q    <= (state_d == DRIVE) || (state_d == DEAD);
      done_q    <= (state_d == FINISH);
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
      if (load_cfg) begin
        num_q  <= bus.num_steps;
        loop_q <= bus.loop;
        dead_q <= bus.dead_time;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == IDLE)) begin
      tbl_state[bus.wr_addr] <= bus.wr_state;
      tbl_dwell[bus.wr_addr] <= bus.wr_dwell;
    end
  end

  assign bus.sw_out   = sw_q;
  assign bus.busy     = busy_q;
  assign bus.step_idx = idx_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.cfg_err  = cfg_err_q;
endmodule
